spi_rx: RTL and testbench

SPI receive-side deserializer for the OLED SPI link: recovers bytes from the `sclk`/`sdin` stream that `spi_cntrl` drives. It is used as a loopback checker in simulation and as the receive end in board-level self-test. It oversamples the SPI pins in the 100 MHz system clock domain and detects `sclk` rising edges (mode 3: idle high, sample on rise). It frames bytes MSB-first, emits a one-cycle `dout_valid` per byte, and flags aborted bytes.

---
 rtl/spi_pkg.sv | 9 +
 rtl/spi_rx_sync_2ff.sv | 28 ++
 rtl/spi_rx.sv | 120 ++++++++++++
 tb/tb_spi_rx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI receive path.
package spi_pkg;

  typedef enum logic {IDLE, SHIFT} spi_rx_state_t;

  localparam int   SPI_W     = 8;
  localparam logic SCLK_IDLE = 1'b1;

endpackage

// File: rtl/spi_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a
// parameterised reset value so the output comes up at the pin's idle level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: state is updated with <= so every flop samples the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_rx.sv
// SPI mode-3 receive deserializer: oversamples sclk/sdin/cs_n in the system
// clock domain, frames MSB-first bytes and flags aborted partial bytes.
module spi_rx
  import spi_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             sdin,
  input  logic             cs_n,
  output logic [SPI_W-1:0] dout,
  output logic             dout_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  localparam int CNT_W = $clog2(SPI_W);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SPI_W - 1);

  logic sclk_s, sdin_s, cs_s;

  sync_2ff #(.RST_VAL(SCLK_IDLE)) u_sync_sclk (
    .clk(clk), .rst(rst), .d_i(sclk), .q_o(sclk_s)
  );
  sync_2ff #(.RST_VAL(1'b0)) u_sync_sdin (
    .clk(clk), .rst(rst), .d_i(sdin), .q_o(sdin_s)
  );
  sync_2ff #(.RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d_i(cs_n), .q_o(cs_s)
  );

  spi_rx_state_t    state_q, state_d;
  logic             sclk_q;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [SPI_W-2:0] shreg_q, shreg_d;
  logic [SPI_W-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             rise;

  assign rise = sclk_s & ~sclk_q;

  // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    tmo_d        = (rise || bit_cnt_q == '0) ? '0 : tmo_q + 1'b1;

    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (!cs_s) state_d = SHIFT;
      end
      SHIFT: begin
        if (rise) begin
          shreg_d = {shreg_q[SPI_W-3:0], sdin_s};
          if (bit_cnt_q == LAST_BIT) begin
            dout_d       = {shreg_q, sdin_s};
            dout_valid_d = 1'b1;
            bit_cnt_d    = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end

        if (cs_s) begin
          state_d = IDLE;
          // A byte finishing on the deselect cycle is kept; anything partial is dropped.
          if (!(rise && bit_cnt_q == LAST_BIT)) begin
            frame_err_d = (bit_cnt_q != '0);
            bit_cnt_d   = '0;
            tmo_d       = '0;
          end
        end else if (!rise && bit_cnt_q != '0 && tmo_q == TMO_LAST) begin
          frame_err_d = 1'b1;
          bit_cnt_d   = '0;
          tmo_d       = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sclk_q       <= SCLK_IDLE;
      bit_cnt_q    <= '0;
      tmo_q        <= '0;
      shreg_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sclk_q       <= sclk_s;
      bit_cnt_q    <= bit_cnt_d;
      tmo_q        <= tmo_d;
      shreg_q      <= shreg_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = (bit_cnt_q != '0);

endmodule

// File: tb/tb_spi_rx.sv
// Scoreboard bench for spi_rx: expected bytes are queued as they are sent
// and popped by a monitor whenever dout_valid pulses.
module tb_spi_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b1;
  logic       sdin = 1'b0;
  logic       cs_n = 1'b1;
  logic [7:0] dout;
  logic       dout_valid;
  logic       frame_err;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int dv_seen  = 0;
  int fe_seen  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  spi_rx #(.TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .sdin(sdin), .cs_n(cs_n),
    .dout(dout), .dout_valid(dout_valid), .frame_err(frame_err), .busy(busy)
  );

  // Monitor: compare every delivered byte against the scoreboard.
  always @(negedge clk) begin
    if (frame_err) fe_seen++;
    if (dout_valid) begin
      logic [7:0] exp_b;
      dv_seen++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_byte: got %h, none expected", dout);
      end else begin
        exp_b = exp_q.pop_front();
        if (dout !== exp_b || frame_err !== 1'b0)
          $display("FAIL byte: got %h fe=%b, expected %h fe=0", dout, frame_err, exp_b);
        else
          n_pass++;
      end
    end
  end

  // Mode 3: data changes on the falling edge, sampled on the rising edge.
  // Each sclk phase is 4 system clocks; busy is sampled after the rise settles.
  task automatic spi_bits(input logic [7:0] val, input int n, input bit chk_busy);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sclk = 1'b0;
      sdin = val[7-i];
      repeat (3) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      if (chk_busy) begin
        n_checks++;
        if (busy !== (i + 1 != 8))
          $display("FAIL busy_bit%0d: got %b, expected %b", i + 1, busy, (i + 1 != 8));
        else
          n_pass++;
      end
    end
  endtask

  task automatic check_counts(input string name, input int dv0, input int fe0,
                              input int dv_exp, input int fe_exp);
    n_checks++;
    if (dv_seen - dv0 !== dv_exp || fe_seen - fe0 !== fe_exp)
      $display("FAIL %s: got dv=%0d fe=%0d, expected dv=%0d fe=%0d", name,
               dv_seen - dv0, fe_seen - fe0, dv_exp, fe_exp);
    else
      n_pass++;
  endtask

  task automatic select(input logic level);
    @(negedge clk);
    cs_n = level;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (dout !== 8'h00 || dout_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset: got dout=%h dv=%b fe=%b busy=%b, expected 00 0 0 0",
               dout, dout_valid, frame_err, busy);
    else
      n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_byte;
    int dv0 = dv_seen, fe0 = fe_seen;
    select(1'b0);
    exp_q.push_back(8'hAB);
    spi_bits(8'hAB, 8, 1'b1);
    repeat (4) @(negedge clk);
    check_counts("single_byte", dv0, fe0, 1, 0);
  endtask

  task automatic test_back_to_back;
    int dv0 = dv_seen, fe0 = fe_seen;
    exp_q.push_back(8'hAB);
    exp_q.push_back(8'hCD);
    spi_bits(8'hAB, 8, 1'b1);
    spi_bits(8'hCD, 4, 1'b1);
    n_checks++;
    if (dout !== 8'hAB) $display("FAIL hold_between: got %h, expected ab", dout);
    else n_pass++;
    spi_bits(8'hD0, 4, 1'b0);
    repeat (4) @(negedge clk);
    check_counts("back_to_back", dv0, fe0, 2, 0);
  endtask

  task automatic test_cs_abort;
    int dv0 = dv_seen, fe0 = fe_seen;
    spi_bits(8'h5A, 3, 1'b1);
    select(1'b1);
    repeat (4) @(negedge clk);
    check_counts("cs_abort", dv0, fe0, 0, 1);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL busy_after_abort: got %b, expected 0", busy);
    else n_pass++;
    select(1'b0);
    exp_q.push_back(8'h3C);
    spi_bits(8'h3C, 8, 1'b0);
    repeat (4) @(negedge clk);
    check_counts("after_abort", dv0, fe0, 1, 1);
  endtask

  task automatic test_timeout;
    int dv0 = dv_seen, fe0 = fe_seen;
    int c = 0;
    bit seen = 1'b0;
    spi_bits(8'h96, 4, 1'b1);
    // Last bit lands 3 cycles after the raw rise, error 64 after that;
    // spi_bits already consumed 4 of those cycles.
    while (!seen && c < 200) begin
      @(negedge clk);
      c++;
      if (frame_err) seen = 1'b1;
    end
    n_checks++;
    if (!seen || c != 64 + 3 - 4)
      $display("FAIL timeout_latency: got %0d cycles (seen=%b), expected %0d", c, seen, 63);
    else
      n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL busy_after_timeout: got %b, expected 0", busy);
    else n_pass++;
    repeat (4) @(negedge clk);
    exp_q.push_back(8'hA5);
    spi_bits(8'hA5, 8, 1'b1);
    repeat (4) @(negedge clk);
    check_counts("timeout", dv0, fe0, 1, 1);
  endtask

  task automatic test_reset_mid_byte;
    int dv0 = dv_seen, fe0 = fe_seen;
    spi_bits(8'h77, 5, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (dout !== 8'h00 || dout_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_mid: got dout=%h dv=%b fe=%b busy=%b, expected 00 0 0 0",
               dout, dout_valid, frame_err, busy);
    else
      n_pass++;
    repeat (6) @(negedge clk);
    exp_q.push_back(8'hFF);
    spi_bits(8'hFF, 8, 1'b1);
    repeat (4) @(negedge clk);
    check_counts("reset_mid", dv0, fe0, 1, 0);
  endtask

  task automatic test_ignored_edges;
    int dv0 = dv_seen, fe0 = fe_seen;
    int bad = 0;
    select(1'b1);
    for (int i = 0; i < 10; i++) begin
      spi_bits(8'($urandom), 1, 1'b0);
      if (busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL ignored_busy: got %0d busy samples, expected 0", bad);
    else n_pass++;
    check_counts("ignored_edges", dv0, fe0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_cs_abort();
    test_timeout();
    test_reset_mid_byte();
    test_ignored_edges();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL leftover: got %0d queued, expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
